// File: rtl/tile_ram_writer_pkg.sv
// Shared types and constants for the tile RAM writer: FSM states, the request
// record stored in the FIFO, field widths and display-side RAM select codes.
package tile_ram_writer_pkg;

  localparam int TILE_BITS   = 6;
  localparam int OFFSET_BITS = 6;
  localparam int COLOR_BITS  = 4;
  localparam int ADDR_BITS   = TILE_BITS + OFFSET_BITS;

  // Display-side RAM select codes; MAP means the tileset RAM is being read.
  localparam logic [1:0] MEM_SEL_MAP  = 2'b01;
  localparam logic [1:0] MEM_SEL_CHAR = 2'b11;

  // Last pixel offset inside a tile; a fill ends after writing this one.
  localparam logic [OFFSET_BITS-1:0] PIX_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                   fill;
    logic [TILE_BITS-1:0]   tile;
    logic [OFFSET_BITS-1:0] offset;
    logic [COLOR_BITS-1:0]  data;
  } req_t;

  localparam int REQ_BITS = $bits(req_t);

  // Pixel address inside the tileset RAM; the offset never carries into the tile.
  function automatic logic [ADDR_BITS-1:0] pix_addr(
    input logic [TILE_BITS-1:0]   tile,
    input logic [OFFSET_BITS-1:0] offset
  );
    return {tile, offset};
  endfunction

endpackage

// File: rtl/tile_ram_writer_if.sv
// Request channel into the tile RAM writer: valid/ready handshake carrying one
// single-pixel write or whole-tile fill request per accepted beat.
interface tile_ram_writer_if;
  import tile_ram_writer_pkg::*;

  logic                   req_valid;
  logic                   req_fill;
  logic [TILE_BITS-1:0]   req_tile;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [COLOR_BITS-1:0]  req_data;
  logic                   req_ready;

  modport master (
    output req_valid,
    output req_fill,
    output req_tile,
    output req_offset,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_fill,
    input  req_tile,
    input  req_offset,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/tile_req_fifo.sv
// Synchronous first-word-fall-through FIFO for buffered write requests.
// DEPTH must be a power of two so the pointers wrap on their own.
module tile_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Overflow and underflow are blocked here so callers can be sloppy.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tile_ram_writer.sv
// Tileset RAM writer: queues pixel writes and whole-tile fills, then drains
// them into the tileset RAM whenever the display side is not reading it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head as soon as one exists
// ST_WRITE | single pixel {tile, offset} pending, waits for a free RAM slot
// ST_FILL  | writing pixels 0..63 of a tile, pausing while the RAM is busy
module tile_ram_writer
  import tile_ram_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  tile_ram_writer_if.slave      req,
  input  logic [1:0]            i_mem_select,
  output logic [ADDR_BITS-1:0]  o_ram_address,
  output logic [COLOR_BITS-1:0] o_ram_data,
  output logic                  o_ram_wren,
  output logic                  o_busy,
  output logic                  o_fill_done
);

  state_t                 state;
  state_t                 state_nxt;
  req_t                   head;
  req_t                   cur;
  req_t                   push_req;
  logic [OFFSET_BITS-1:0] pix_cnt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   ram_busy;
  logic                   fill_last;

  assign push_req = '{fill:   req.req_fill,
                      tile:   req.req_tile,
                      offset: req.req_offset,
                      data:   req.req_data};

  assign req.req_ready = ~fifo_full;
  assign fifo_push     = req.req_valid & ~fifo_full;
  assign ram_busy      = (i_mem_select == MEM_SEL_MAP);
  assign fill_last     = (state == ST_FILL) & o_ram_wren & (pix_cnt == PIX_LAST);
  assign o_busy        = (state != ST_IDLE) | ~fifo_empty;

  tile_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_BITS)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .din   (push_req),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, FIFO pop and RAM write port; the write enable follows the
  // RAM select combinationally so a display read blocks the slot instantly.
  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    o_ram_wren    = 1'b0;
    o_ram_address = '0;
    o_ram_data    = '0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = head.fill ? ST_FILL : ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_ram_wren    = ~ram_busy;
        o_ram_address = pix_addr(cur.tile, cur.offset);
        o_ram_data    = cur.data;
        if (!ram_busy) state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        o_ram_wren    = ~ram_busy;
        o_ram_address = pix_addr(cur.tile, pix_cnt);
        o_ram_data    = cur.data;
        if (!ram_busy && (pix_cnt == PIX_LAST)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latched request, pixel counter and the one-cycle fill-complete pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cur         <= '0;
      pix_cnt     <= '0;
      o_fill_done <= 1'b0;
    end else begin
      o_fill_done <= fill_last;
      if (fifo_pop) begin
        cur     <= head;
        pix_cnt <= '0;
      end else if ((state == ST_FILL) && o_ram_wren) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/tile_ram_writer.md
TILE_RAM_WRITER -- requirements
Module: tile_ram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered write requests (power of two, >=2).
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  SHALL be synchronous, active-low reset.
REQ-004 i_req_valid  in  1  SHALL mark a write request presented this cycle.
REQ-005 i_req_fill  in  1  SHALL select a whole-tile fill (1) or single-pixel write (0).
REQ-006 i_req_tile  in  6  SHALL give the target tile index 0..63.
REQ-007 i_req_offset  in  6  SHALL give the pixel offset within the tile; ignored when i_req_fill=1.
REQ-008 i_req_data  in  4  SHALL give the 4-bit palette colour code.
REQ-009 o_req_ready  out  1  SHALL be high when the request FIFO can accept an entry.
REQ-010 i_mem_select  in  2  SHALL be the display-side RAM select; the RAM SHALL count as busy when it equals 2'b01 (map/tile read).
REQ-011 o_ram_address  out  12  SHALL be the tileset RAM write address.
REQ-012 o_ram_data  out  4  SHALL be the tileset RAM write data.
REQ-013 o_ram_wren  out  1  SHALL be the tileset RAM write enable.
REQ-014 o_busy  out  1  SHALL be high while any request is queued or in progress.
REQ-015 o_fill_done  out  1  SHALL pulse high one cycle when a fill completes.

Function
REQ-016 A request SHALL be accepted on an edge where i_req_valid and o_req_ready are both high; {fill, tile, offset, data} SHALL be pushed in order.
REQ-017 o_req_ready SHALL be low exactly when the FIFO holds FIFO_DEPTH entries; a valid request while full SHALL be neither stored nor lost from the FIFO (requester holds it).
REQ-018 A push and a pop on the same edge SHALL leave the occupancy unchanged; pop SHALL never occur when empty.
REQ-019 The FSM SHALL have states IDLE, WRITE, FILL.
REQ-020 IDLE: when the FIFO is non-empty, pop the head, latch it, go to WRITE (fill=0) or FILL (fill=1) with pixel counter cleared to 0; otherwise stay.
REQ-021 o_ram_wren SHALL equal (state is WRITE or FILL) AND (i_mem_select != 2'b01), combinationally.
REQ-022 Write address SHALL be {tile, offset} in WRITE and {tile, counter} in FILL (tile*64 + offset, no carry into other tiles).
REQ-023 o_ram_data SHALL be the latched colour during WRITE/FILL; o_ram_address and o_ram_data SHALL be 0 in IDLE.
REQ-024 WRITE: on an edge with o_ram_wren high, return to IDLE; with RAM busy, hold all state.
REQ-025 FILL: on each edge with o_ram_wren high, increment counter; the write of counter 63 SHALL return to IDLE and assert o_fill_done next cycle; RAM busy SHALL pause with counter held.
REQ-026 Latency: request accepted at edge N SHALL produce its first o_ram_wren in the cycle after edge N+1 when the FIFO was empty, FSM IDLE and RAM free.
REQ-027 An uninterrupted fill SHALL take exactly 64 consecutive wren cycles.
REQ-028 o_busy SHALL equal (state != IDLE) OR (FIFO non-empty).

Reset
REQ-029 While i_rst_n is low at an edge: state IDLE, FIFO empty, counter 0, latched request 0, o_fill_done 0.
REQ-030 After reset o_ram_wren, o_ram_address, o_ram_data, o_busy SHALL be 0 and o_req_ready 1; reset mid-fill SHALL abandon the fill with no further writes.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, MEM_SEL_MAP=2'b01 / MEM_SEL_CHAR=2'b11 constants, and TILE_BITS=6, OFFSET_BITS=6, COLOR_BITS=4.
REQ-032 The request FIFO SHALL be a sub-module tile_req_fifo (synchronous, first-word visible, full/empty flags).

Verification
REQ-033 Single write: tile 5, offset 9, data 7, i_mem_select=2'b00 -> one wren cycle, address 12'h149, data 4'h7, two cycles after acceptance.
REQ-034 Fill: tile 2, data 3, RAM free -> 64 consecutive wrens, addresses 0x080..0x0BF, o_fill_done one cycle after the last.
REQ-035 Stall: i_mem_select=2'b01 for 10 cycles mid-fill at counter 20 -> wren low 10 cycles, resumes at address {tile,20}, no skipped/duplicated address.
REQ-036 Backpressure: 6 back-to-back requests while i_mem_select=2'b01 -> ready drops after 5th accepted (4 queued + 1 latched), all 5 written in order once released.
REQ-037 Reset at fill counter 30 -> wren 0 next cycle, o_busy 0, ready 1, no fill_done.
